// File: rtl/gpio_axil_arbiter.sv
// rtl/gpio_axil_arbiter.sv - round-robin share of one AXI4-Lite master port between two requesters
module gpio_axil_arbiter #(
    parameter int C_ADDR_WIDTH = 4,
    parameter int C_DATA_WIDTH = 32
) (
    input  logic                        ACLK,
    input  logic                        ARESETN,
    input  logic [1:0]                  req_valid,
    output logic [1:0]                  req_ready,
    input  logic [1:0]                  req_we,
    input  logic [2*C_ADDR_WIDTH-1:0]   req_addr,
    input  logic [2*C_DATA_WIDTH-1:0]   req_wdata,
    output logic [1:0]                  rsp_valid,
    output logic [C_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                  rsp_resp,
    output logic [C_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                  M_AXI_AWPROT,
    output logic                        M_AXI_AWVALID,
    input  logic                        M_AXI_AWREADY,
    output logic [C_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                        M_AXI_WVALID,
    input  logic                        M_AXI_WREADY,
    input  logic [1:0]                  M_AXI_BRESP,
    input  logic                        M_AXI_BVALID,
    output logic                        M_AXI_BREADY,
    output logic [C_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                  M_AXI_ARPROT,
    output logic                        M_AXI_ARVALID,
    input  logic                        M_AXI_ARREADY,
    input  logic [C_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                  M_AXI_RRESP,
    input  logic                        M_AXI_RVALID,
    output logic                        M_AXI_RREADY
);
    typedef enum logic [2:0] {S_IDLE, S_WR, S_WR_B, S_RD_AR, S_RD_R, S_RSP} state_t;

    localparam logic [C_ADDR_WIDTH-1:0] WORD_MASK = {{(C_ADDR_WIDTH-2){1'b1}}, 2'b00};

    state_t                  state_q, state_d;
    logic                    last_grant_q, owner_q;
    logic [C_ADDR_WIDTH-1:0] addr_q;
    logic [C_DATA_WIDTH-1:0] wdata_q, rdata_q;
    logic [1:0]              resp_q;
    logic                    awvalid_q, awvalid_d, wvalid_q, wvalid_d;
    logic                    grant, grant_vld, grant_we;
    logic                    aw_ok, w_ok;

    // On a tie the requester that did not win last time is served.
    always_comb begin
        grant_vld = |req_valid;
        grant     = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];
        grant_we  = req_we[grant];
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // AW and W are tracked separately so either channel may complete first.
    always_comb begin
        state_d   = state_q;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        aw_ok     = !awvalid_q || M_AXI_AWREADY;
        w_ok      = !wvalid_q || M_AXI_WREADY;
        case (state_q)
            S_IDLE: begin
                if (grant_vld) begin
                    state_d   = grant_we ? S_WR : S_RD_AR;
                    awvalid_d = grant_we;
                    wvalid_d  = grant_we;
                end
            end
            S_WR: begin
                awvalid_d = !aw_ok;
                wvalid_d  = !w_ok;
                if (aw_ok && w_ok) begin
                    state_d = S_WR_B;
                end
            end
            S_WR_B:  if (M_AXI_BVALID)  state_d = S_RSP;
            S_RD_AR: if (M_AXI_ARREADY) state_d = S_RD_R;
            S_RD_R:  if (M_AXI_RVALID)  state_d = S_RSP;
            S_RSP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        if (state_q == S_IDLE && grant_vld) begin
            req_ready = {grant, ~grant};
        end
        if (state_q == S_RSP) begin
            rsp_valid = {owner_q, ~owner_q};
        end
        rsp_rdata     = rdata_q;
        rsp_resp      = resp_q;
        M_AXI_AWADDR  = addr_q & WORD_MASK;
        M_AXI_AWPROT  = 3'b000;
        M_AXI_AWVALID = awvalid_q;
        M_AXI_WDATA   = wdata_q;
        M_AXI_WSTRB   = '1;
        M_AXI_WVALID  = wvalid_q;
        M_AXI_BREADY  = (state_q == S_WR_B);
        M_AXI_ARADDR  = addr_q & WORD_MASK;
        M_AXI_ARPROT  = 3'b000;
        M_AXI_ARVALID = (state_q == S_RD_AR);
        M_AXI_RREADY  = (state_q == S_RD_R);
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            resp_q       <= 2'b00;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
        end else begin
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            if (state_q == S_IDLE && grant_vld) begin
                owner_q      <= grant;
                last_grant_q <= grant;
                addr_q       <= grant ? req_addr[2*C_ADDR_WIDTH-1:C_ADDR_WIDTH]
                                      : req_addr[C_ADDR_WIDTH-1:0];
                wdata_q      <= grant ? req_wdata[2*C_DATA_WIDTH-1:C_DATA_WIDTH]
                                      : req_wdata[C_DATA_WIDTH-1:0];
            end
            if (state_q == S_WR_B && M_AXI_BVALID) begin
                resp_q  <= M_AXI_BRESP;
                rdata_q <= '0;
            end
            if (state_q == S_RD_R && M_AXI_RVALID) begin
                resp_q  <= M_AXI_RRESP;
                rdata_q <= M_AXI_RDATA;
            end
        end
    end
endmodule

// File: tb/tb_gpio_axil_arbiter.sv
// tb/tb_gpio_axil_arbiter.sv - randomized self-checking bench for gpio_axil_arbiter
module tb_gpio_axil_arbiter;
    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic [1:0]  req_valid = '0, req_ready, req_we = '0, rsp_valid, rsp_resp;
    logic [7:0]  req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [31:0] rsp_rdata;
    logic [3:0]  M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WSTRB;
    logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
    logic        M_AXI_AWVALID, M_AXI_AWREADY = 0, M_AXI_WVALID, M_AXI_WREADY = 0;
    logic [31:0] M_AXI_WDATA, M_AXI_RDATA = '0;
    logic [1:0]  M_AXI_BRESP = '0, M_AXI_RRESP = '0;
    logic        M_AXI_BVALID = 0, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY = 0;
    logic        M_AXI_RVALID = 0, M_AXI_RREADY;

    gpio_axil_arbiter #(.C_ADDR_WIDTH(4), .C_DATA_WIDTH(32)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    always #5 ACLK = ~ACLK;

    typedef struct packed {
        logic        we;
        logic [3:0]  addr;
        logic [31:0] wdata;
    } cmd_t;

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic cmd_t mk(input logic we, input logic [3:0] a, input logic [31:0] d);
        cmd_t c;
        c.we = we; c.addr = a; c.wdata = d;
        return c;
    endfunction

    cmd_t q0[$], q1[$];
    int   dut_log[$];
    int   cyc = 0;
    bit   rnd = 0;

    // reference register file and transaction expectations
    logic [31:0] ref_mem [4];
    bit          m_busy, m_owner, m_last = 1;
    int          m_start, m_lat;
    logic [31:0] m_rdata;
    logic [1:0]  m_resp;
    cmd_t        m_cmd;
    int          obs_lat;
    logic [31:0] obs_rdata;
    logic [1:0]  obs_resp;

    // slave bus model
    logic [31:0] smem [4];
    int          d_aw, d_w, d_ar, aw_wait, w_wait, ar_wait, aw_hi, w_hi, ar_hi;
    bit          aw_done, w_done, b_issued, b_pend, ar_done, r_pend, hold_b, force_r;
    logic [3:0]  aw_addr;
    logic [31:0] w_data, r_data, force_data;
    logic [1:0]  cfg_bresp, cfg_rresp, r_resp;

    task automatic clear_state();
        q0.delete(); q1.delete();
        m_busy = 0; m_last = 1;
        {aw_done, w_done, b_issued, b_pend, ar_done, r_pend, hold_b, force_r} = '0;
        {aw_wait, w_wait, ar_wait, aw_hi, w_hi, ar_hi, d_aw, d_w, d_ar} = '0;
        cfg_bresp = 0; cfg_rresp = 0;
    endtask

    task automatic drive_req();
        req_valid = 2'b00;
        if (q0.size() > 0) begin
            req_valid[0] = 1'b1; req_we[0] = q0[0].we;
            req_addr[3:0] = q0[0].addr; req_wdata[31:0] = q0[0].wdata;
        end
        if (q1.size() > 0) begin
            req_valid[1] = 1'b1; req_we[1] = q1[0].we;
            req_addr[7:4] = q1[0].addr; req_wdata[63:32] = q1[0].wdata;
        end
    endtask

    task automatic cycle();
        logic [1:0] exp_rdy, exp_rsp;
        int r;
        @(negedge ACLK);
        cyc++;
        M_AXI_BVALID  = b_pend && !hold_b;
        M_AXI_BRESP   = M_AXI_BVALID ? cfg_bresp : 2'b00;
        M_AXI_RVALID  = r_pend;
        M_AXI_RDATA   = r_pend ? r_data : 32'h0;
        M_AXI_RRESP   = r_pend ? r_resp : 2'b00;
        M_AXI_AWREADY = M_AXI_AWVALID && (aw_wait >= d_aw);
        M_AXI_WREADY  = M_AXI_WVALID && (w_wait >= d_w);
        M_AXI_ARREADY = M_AXI_ARVALID && (ar_wait >= d_ar);
        drive_req();
        #1;
        if (aw_done) check("awvalid_drop", M_AXI_AWVALID, 0);
        if (w_done)  check("wvalid_drop", M_AXI_WVALID, 0);
        if (ar_done) check("arvalid_drop", M_AXI_ARVALID, 0);
        if (M_AXI_BVALID && M_AXI_BREADY) begin
            {b_pend, aw_done, w_done, b_issued} = '0;
            aw_hi = 0; w_hi = 0;
        end
        if (M_AXI_RVALID && M_AXI_RREADY) begin
            check("ar_cycles", ar_hi, d_ar + 1);
            r_pend = 0; ar_done = 0; ar_hi = 0;
        end
        if (M_AXI_AWVALID) begin
            aw_hi++;
            if (M_AXI_AWREADY) begin
                check("awaddr", M_AXI_AWADDR, {m_cmd.addr[3:2], 2'b00});
                check("awprot", M_AXI_AWPROT, 0);
                aw_done = 1; aw_addr = M_AXI_AWADDR; aw_wait = 0;
            end else aw_wait++;
        end
        if (M_AXI_WVALID) begin
            w_hi++;
            if (M_AXI_WREADY) begin
                check("wdata", M_AXI_WDATA, m_cmd.wdata);
                check("wstrb", M_AXI_WSTRB, 4'hF);
                w_done = 1; w_data = M_AXI_WDATA; w_wait = 0;
            end else w_wait++;
        end
        if (aw_done && w_done && !b_issued) begin
            check("aw_cycles", aw_hi, d_aw + 1);
            check("w_cycles", w_hi, d_w + 1);
            smem[aw_addr[3:2]] = w_data;
            b_issued = 1; b_pend = 1;
        end
        if (M_AXI_ARVALID) begin
            ar_hi++;
            if (M_AXI_ARREADY) begin
                check("araddr", M_AXI_ARADDR, {m_cmd.addr[3:2], 2'b00});
                check("arprot", M_AXI_ARPROT, 0);
                r_data = force_r ? force_data : smem[M_AXI_ARADDR[3:2]];
                r_resp = cfg_rresp; r_pend = 1; ar_done = 1; ar_wait = 0;
            end else ar_wait++;
        end
        exp_rdy = 2'b00;
        if (!m_busy) begin
            if (req_valid == 2'b11) exp_rdy = m_last ? 2'b01 : 2'b10;
            else exp_rdy = req_valid;
        end
        check("req_ready", req_ready, exp_rdy);
        if (req_ready != 2'b00) dut_log.push_back(int'(req_ready[1]));
        exp_rsp = (m_busy && cyc == m_start + m_lat) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
        check("rsp_valid", rsp_valid, exp_rsp);
        if (rsp_valid != 2'b00) begin
            obs_lat = cyc - m_start; obs_rdata = rsp_rdata; obs_resp = rsp_resp;
        end
        if (exp_rsp != 2'b00) begin
            check("rsp_rdata", rsp_rdata, m_rdata);
            check("rsp_resp", rsp_resp, m_resp);
            m_busy = 0;
        end
        if (exp_rdy != 2'b00) begin
            r = exp_rdy[1] ? 1 : 0;
            m_cmd = r ? q1.pop_front() : q0.pop_front();
            if (rnd) begin
                d_aw = $urandom_range(0, 3); d_w = $urandom_range(0, 3); d_ar = $urandom_range(0, 3);
                cfg_bresp = 2'($urandom_range(0, 3)); cfg_rresp = 2'($urandom_range(0, 3));
            end
            m_busy = 1; m_owner = r[0]; m_last = r[0]; m_start = cyc;
            if (m_cmd.we) begin
                ref_mem[m_cmd.addr[3:2]] = m_cmd.wdata;
                m_rdata = 32'h0; m_resp = cfg_bresp;
                m_lat = hold_b ? 100000 : 3 + ((d_aw > d_w) ? d_aw : d_w);
            end else begin
                m_rdata = force_r ? force_data : ref_mem[m_cmd.addr[3:2]];
                m_resp = cfg_rresp; m_lat = 3 + d_ar;
            end
        end
    endtask

    task automatic run_until_idle(input int max_cyc);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || m_busy) && n < max_cyc) begin
            cycle();
            n++;
        end
        check("drain", {q0.size() != 0, q1.size() != 0, m_busy}, 3'b000);
    endtask

    task automatic reset_and_check();
        ARESETN = 0; req_valid = 2'b00;
        {M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BVALID, M_AXI_ARREADY, M_AXI_RVALID} = '0;
        @(negedge ACLK); #1;
        check("rst_ctl", {req_ready, rsp_valid, rsp_resp, M_AXI_AWVALID, M_AXI_WVALID,
                          M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 0);
        check("rst_rdata", rsp_rdata, 0);
        check("rst_addr", {M_AXI_AWADDR, M_AXI_ARADDR}, 0);
        check("rst_wdata", M_AXI_WDATA, 0);
        ARESETN = 1;
        clear_state();
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin ref_mem[i] = 0; smem[i] = 0; end
        clear_state();
        repeat (2) @(posedge ACLK);
        reset_and_check();

        // 1: req0 write, always-ready slave
        q0.push_back(mk(1, 4'h4, 32'h0000_00A5));
        run_until_idle(20);
        check("t1_lat", obs_lat, 3);
        check("t1_resp", obs_resp, 2'b00);
        // 2: req1 reads it back
        q1.push_back(mk(0, 4'h4, 32'h0));
        run_until_idle(20);
        check("t2_lat", obs_lat, 3);
        check("t2_rdata", obs_rdata, 32'h0000_00A5);
        // 3: both requesters busy, strict alternation
        dut_log.delete();
        for (int i = 0; i < 4; i++) begin
            q0.push_back(mk(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom));
            q1.push_back(mk(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom));
        end
        run_until_idle(100);
        check("t3_grants", dut_log.size(), 8);
        for (int i = 0; i < dut_log.size(); i++) check("t3_order", dut_log[i], i % 2);
        // 4: AWREADY delayed 3 cycles
        d_aw = 3; d_w = 0;
        q0.push_back(mk(1, 4'h8, 32'h1234_5678));
        run_until_idle(30);
        check("t4_lat", obs_lat, 6);
        d_aw = 0;
        // 5: read with SLVERR and forced data
        force_r = 1; force_data = 32'hDEAD_BEEF; cfg_rresp = 2'b10;
        q1.push_back(mk(0, 4'hC, 32'h0));
        run_until_idle(20);
        check("t5_resp", obs_resp, 2'b10);
        check("t5_rdata", obs_rdata, 32'hDEAD_BEEF);
        force_r = 0; cfg_rresp = 2'b00;
        q0.push_back(mk(0, 4'h8, 32'h0));
        cycle();
        check("t5_idle", req_ready, 2'b01);
        run_until_idle(20);
        check("t5_rd", obs_rdata, 32'h1234_5678);
        // randomized traffic with random slave stalls and responses
        rnd = 1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0 && q0.size() < 3)
                q0.push_back(mk(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom));
            if ($urandom_range(0, 3) == 0 && q1.size() < 3)
                q1.push_back(mk(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom));
            cycle();
        end
        run_until_idle(300);
        rnd = 0; d_aw = 0; d_w = 0; d_ar = 0; cfg_bresp = 0; cfg_rresp = 0;
        // 6: reset while waiting for B
        hold_b = 1;
        q0.push_back(mk(1, 4'h0, 32'h5555_AAAA));
        for (int i = 0; i < 20 && !M_AXI_BREADY; i++) cycle();
        check("t6_wrb", M_AXI_BREADY, 1);
        reset_and_check();
        dut_log.delete();
        q0.push_back(mk(0, 4'h0, 32'h0));
        q1.push_back(mk(0, 4'h4, 32'h0));
        run_until_idle(30);
        check("t6_grants", dut_log.size(), 2);
        if (dut_log.size() > 0) check("t6_first", dut_log[0], 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
